// File: rtl/voltage_scale_ctrl_pkg.sv
// Shared types and constants for the oscilloscope voltage-scaling path.
package osc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, UPDATE} state_e;

  localparam logic [2:0]  SCALE_MIN = 3'd0;
  localparam logic [2:0]  SCALE_MAX = 3'd4;
  localparam int unsigned SAMPLE_W  = 12;
  localparam int unsigned SCALED_W  = 25;

  // Single saturating step; simultaneous up and down cancel out.
  function automatic logic [2:0] scale_step(input logic [2:0] s, input logic up, input logic dn);
    if (up && !dn && s < SCALE_MAX) return s + 3'd1;
    if (dn && !up && s > SCALE_MIN) return s - 3'd1;
    return s;
  endfunction

endpackage

// File: rtl/voltage_scale_ctrl_frame_stats.sv
// Per-frame running max/min/sum with a published snapshot loaded at frame end.
module frame_stats
  import osc_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                acc_en,
  input  logic                load,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0] run_max,
  output logic [SAMPLE_W-1:0] mean,
  output logic [SAMPLE_W-1:0] peak_max,
  output logic [SAMPLE_W-1:0] peak_min
);

  localparam int unsigned SUM_W = ADDR_W + SAMPLE_W;

  logic [SAMPLE_W-1:0] run_max_q, run_max_d, run_min_q, run_min_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [SAMPLE_W-1:0] mean_q, mean_d, peak_max_q, peak_max_d, peak_min_q, peak_min_d;

  always_comb begin
    run_max_d  = run_max_q;
    run_min_d  = run_min_q;
    sum_d      = sum_q;
    mean_d     = mean_q;
    peak_max_d = peak_max_q;
    peak_min_d = peak_min_q;
    if (clr) begin
      run_max_d = '0;
      run_min_d = '1;
      sum_d     = '0;
    end else if (acc_en) begin
      if (sample > run_max_q) run_max_d = sample;
      if (sample < run_min_q) run_min_d = sample;
      sum_d = sum_q + SUM_W'(sample);
    end
    if (load) begin
      mean_d     = sum_q[ADDR_W +: SAMPLE_W];
      peak_max_d = run_max_q;
      peak_min_d = run_min_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_max_q  <= '0;
      run_min_q  <= '1;
      sum_q      <= '0;
      mean_q     <= '0;
      peak_max_q <= '0;
      peak_min_q <= '1;
    end else begin
      run_max_q  <= run_max_d;
      run_min_q  <= run_min_d;
      sum_q      <= sum_d;
      mean_q     <= mean_d;
      peak_max_q <= peak_max_d;
      peak_min_q <= peak_min_d;
    end
  end

  assign run_max  = run_max_q;
  assign mean     = mean_q;
  assign peak_max = peak_max_q;
  assign peak_min = peak_min_q;

endmodule

// File: rtl/voltage_scale_ctrl.sv
// Frame sequencer: walks capture RAM, streams scaled samples to display RAM,
// gathers statistics and picks the next SCALE (auto-range or manual buttons).
module voltage_scale_ctrl
  import osc_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned PIPE_LAT   = 2,
  parameter logic [11:0] HI_THR     = 12'd3800,
  parameter logic [11:0] LO_THR     = 12'd300,
  parameter logic [2:0]  INIT_SCALE = 3'd2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                START,
  input  logic                AUTO_EN,
  input  logic                BTN_UP,
  input  logic                BTN_DN,
  output logic [ADDR_W-1:0]   RD_ADDR,
  input  logic [SAMPLE_W-1:0] RD_DATA,
  input  logic [SCALED_W-1:0] SCALED_IN,
  output logic [2:0]          SCALE,
  output logic [SAMPLE_W-1:0] MEAN,
  output logic [SAMPLE_W-1:0] PEAK_MAX,
  output logic [SAMPLE_W-1:0] PEAK_MIN,
  output logic [ADDR_W-1:0]   WR_ADDR,
  output logic [SCALED_W-1:0] WR_DATA,
  output logic                WR_EN,
  output logic                BUSY,
  output logic                DONE
);

  localparam int unsigned DCW = $clog2(PIPE_LAT) + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DCW-1:0]      drain_cnt_q, drain_cnt_d;
  logic [PIPE_LAT-1:0] vld_q, vld_d;
  logic [ADDR_W-1:0]   addr_q [PIPE_LAT];
  logic [ADDR_W-1:0]   addr_d [PIPE_LAT];
  logic [2:0]          scale_q, scale_d;
  logic                pend_q, pend_d, pend_up_q, pend_up_d;
  logic                done_q, done_d;
  logic                clr, load, btn_valid;
  logic [SAMPLE_W-1:0] run_max;

  assign btn_valid = (BTN_UP ^ BTN_DN) && !AUTO_EN;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    drain_cnt_d = drain_cnt_q;
    scale_d     = scale_q;
    pend_d      = pend_q;
    pend_up_d   = pend_up_q;
    done_d      = 1'b0;
    clr         = 1'b0;
    load        = 1'b0;

    vld_d[0]  = (state_q == RUN);
    addr_d[0] = rd_addr_q;
    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      addr_d[i] = addr_q[i-1];
    end

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d   = RUN;
          rd_addr_d = '0;
          clr       = 1'b1;
          if (btn_valid) begin
            pend_d    = 1'b1;
            pend_up_d = BTN_UP;
          end
        end else if (btn_valid) begin
          scale_d = scale_step(scale_q, BTN_UP, BTN_DN);
        end
      end
      RUN: begin
        rd_addr_d = rd_addr_q + 1'b1;
        if (rd_addr_q == '1) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (drain_cnt_q == DCW'(PIPE_LAT - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        state_d = IDLE;
        load    = 1'b1;
        done_d  = 1'b1;
        pend_d  = 1'b0;
        // Auto decision uses the final running max, i.e. the PEAK_MAX being published now.
        if (AUTO_EN) begin
          if (run_max >= HI_THR && scale_q < SCALE_MAX)     scale_d = scale_q + 3'd1;
          else if (run_max < LO_THR && scale_q > SCALE_MIN) scale_d = scale_q - 3'd1;
        end else if (btn_valid) begin
          scale_d = scale_step(scale_q, BTN_UP, BTN_DN);
        end else if (pend_q) begin
          scale_d = scale_step(scale_q, pend_up_q, !pend_up_q);
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == RUN || state_q == DRAIN) && btn_valid) begin
      pend_d    = 1'b1;
      pend_up_d = BTN_UP;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      drain_cnt_q <= '0;
      vld_q       <= '0;
      for (int unsigned i = 0; i < PIPE_LAT; i++) addr_q[i] <= '0;
      scale_q     <= INIT_SCALE;
      pend_q      <= 1'b0;
      pend_up_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      drain_cnt_q <= drain_cnt_d;
      vld_q       <= vld_d;
      for (int unsigned i = 0; i < PIPE_LAT; i++) addr_q[i] <= addr_d[i];
      scale_q     <= scale_d;
      pend_q      <= pend_d;
      pend_up_q   <= pend_up_d;
      done_q      <= done_d;
    end
  end

  frame_stats #(.ADDR_W(ADDR_W)) u_stats (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clr      (clr),
    .acc_en   (vld_q[0]),
    .load     (load),
    .sample   (RD_DATA),
    .run_max  (run_max),
    .mean     (MEAN),
    .peak_max (PEAK_MAX),
    .peak_min (PEAK_MIN)
  );

  assign RD_ADDR = rd_addr_q;
  assign WR_EN   = vld_q[PIPE_LAT-1];
  assign WR_ADDR = addr_q[PIPE_LAT-1];
  assign WR_DATA = SCALED_IN;
  assign SCALE   = scale_q;
  assign BUSY    = (state_q != IDLE);
  assign DONE    = done_q;

endmodule

// File: tb/tb_voltage_scale_ctrl.sv
// Directed bench for voltage_scale_ctrl with a write scoreboard and RAM/scaler models.
module tb_voltage_scale_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, auto_en, btn_up, btn_dn;
  logic [9:0]  rd_addr, wr_addr;
  logic [11:0] rd_data, mean, peak_max, peak_min;
  logic [24:0] scaled, wr_data;
  logic [2:0]  scale;
  logic        wr_en, busy, done;

  logic [11:0] ram [1024];

  typedef struct {
    logic [9:0]  addr;
    logic [24:0] data;
  } wr_t;
  wr_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  voltage_scale_ctrl #(
    .ADDR_W     (10),
    .PIPE_LAT   (2),
    .HI_THR     (12'd3800),
    .LO_THR     (12'd300),
    .INIT_SCALE (3'd2)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .START     (start),
    .AUTO_EN   (auto_en),
    .BTN_UP    (btn_up),
    .BTN_DN    (btn_dn),
    .RD_ADDR   (rd_addr),
    .RD_DATA   (rd_data),
    .SCALED_IN (scaled),
    .SCALE     (scale),
    .MEAN      (mean),
    .PEAK_MAX  (peak_max),
    .PEAK_MIN  (peak_min),
    .WR_ADDR   (wr_addr),
    .WR_DATA   (wr_data),
    .WR_EN     (wr_en),
    .BUSY      (busy),
    .DONE      (done)
  );

  // Capture RAM (1-cycle read) followed by a 1-cycle scaler that tags data with SCALE.
  always @(posedge clk) begin
    rd_data <= ram[rd_addr];
    scaled  <= {scale, 10'd0, rd_data};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_cnt++;
      if (sb_q.size() == 0) begin
        chk("wr_unexpected", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic fill(input bit ramp, input logic [11:0] v);
    for (int i = 0; i < 1024; i++) ram[i] = ramp ? 12'(i) : v;
  endtask

  task automatic press(input logic up, input logic dn, input logic [2:0] exp_scale);
    btn_up = up;
    btn_dn = dn;
    @(negedge clk);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    chk("scale_idle_btn", 32'(scale), 32'(exp_scale));
  endtask

  task automatic frame(input logic [2:0] scale_now, input logic [2:0] scale_after,
                       input int btn_at, input bit restart);
    int unsigned sum = 0;
    logic [11:0] mx = '0;
    logic [11:0] mn = '1;
    int wr0, d0, k;
    for (int i = 0; i < 1024; i++) begin
      sum += ram[i];
      if (ram[i] > mx) mx = ram[i];
      if (ram[i] < mn) mn = ram[i];
      sb_q.push_back('{addr: 10'(i), data: {scale_now, 10'd0, ram[i]}});
    end
    wr0 = wr_cnt;
    d0  = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      chk("rd_addr", 32'(rd_addr), 32'(i));
      chk("busy_run", 32'(busy), 32'd1);
      chk("scale_run", 32'(scale), 32'(scale_now));
      chk("wr_en_run", 32'(wr_en), 32'(i >= 2));
      if (i == btn_at) btn_up = 1'b1;
      if (restart && (i == 5 || i == 1023)) start = 1'b1;
      @(negedge clk);
      btn_up = 1'b0;
      start  = 1'b0;
    end
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      chk("scale_drain", 32'(scale), 32'(scale_now));
      @(negedge clk);
      k++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("scale_done", 32'(scale), 32'(scale_after));
    chk("mean", 32'(mean), 32'(sum >> 10));
    chk("peak_max", 32'(peak_max), 32'(mx));
    chk("peak_min", 32'(peak_min), 32'(mn));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("wr_count", 32'(wr_cnt - wr0), 32'd1024);
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; auto_en = 1'b0; btn_up = 1'b0; btn_dn = 1'b0;
    fill(1'b1, 12'd0);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_scale", 32'(scale), 32'd2);
    chk("rst_mean", 32'(mean), 32'd0);
    chk("rst_peak_max", 32'(peak_max), 32'd0);
    chk("rst_peak_min", 32'(peak_min), 32'hFFF);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a frame.
    for (int i = 0; i < 1024; i++) sb_q.push_back('{addr: 10'(i), data: {3'd2, 10'd0, ram[i]}});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      chk("rd_addr_pre_rst", 32'(rd_addr), 32'(i));
      @(negedge clk);
    end
    chk("rd_addr_500", 32'(rd_addr), 32'd500);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_scale", 32'(scale), 32'd2);
    chk("mid_rst_peak_min", 32'(peak_min), 32'hFFF);
    chk("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
    @(negedge clk);
    chk("mid_rst_wr_en2", 32'(wr_en), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);

    frame(3'd2, 3'd2, -1, 1'b0);
    frame(3'd2, 3'd2, -1, 1'b1);
    frame(3'd2, 3'd3, 10, 1'b0);

    press(1'b1, 1'b1, 3'd3);
    press(1'b1, 1'b0, 3'd4);
    press(1'b1, 1'b0, 3'd4);
    press(1'b1, 1'b0, 3'd4);
    press(1'b1, 1'b0, 3'd4);
    press(1'b0, 1'b1, 3'd3);
    press(1'b0, 1'b1, 3'd2);
    press(1'b0, 1'b1, 3'd1);
    press(1'b0, 1'b1, 3'd0);
    press(1'b0, 1'b1, 3'd0);
    press(1'b1, 1'b0, 3'd1);
    press(1'b1, 1'b0, 3'd2);

    auto_en = 1'b1;
    press(1'b1, 1'b0, 3'd2);
    fill(1'b0, 12'd4000);
    frame(3'd2, 3'd3, -1, 1'b0);
    frame(3'd3, 3'd4, -1, 1'b0);
    frame(3'd4, 3'd4, -1, 1'b0);

    auto_en = 1'b0;
    press(1'b0, 1'b1, 3'd3);
    press(1'b0, 1'b1, 3'd2);
    press(1'b0, 1'b1, 3'd1);
    auto_en = 1'b1;
    fill(1'b0, 12'd100);
    frame(3'd1, 3'd0, -1, 1'b0);
    frame(3'd0, 3'd0, -1, 1'b0);

    auto_en = 1'b0;
    press(1'b1, 1'b0, 3'd1);
    press(1'b1, 1'b0, 3'd2);
    auto_en = 1'b1;
    fill(1'b0, 12'd2000);
    frame(3'd2, 3'd2, -1, 1'b0);

    fill(1'b0, 12'd3799);
    frame(3'd2, 3'd2, -1, 1'b0);
    fill(1'b0, 12'd3800);
    frame(3'd2, 3'd3, -1, 1'b0);
    fill(1'b0, 12'd300);
    frame(3'd3, 3'd3, -1, 1'b0);
    fill(1'b0, 12'd299);
    frame(3'd3, 3'd2, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
